// File: rtl/led_ctrl_pkg.sv
// Shared mode encodings and display patterns for the front-panel LED controller.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_GATE  = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  // BLINK patterns, LED4..LED1
  localparam logic [3:0] BLINK_PAT_A = 4'b0101;
  localparam logic [3:0] BLINK_PAT_B = 4'b1010;

  function automatic mode_e next_mode(input mode_e m);
    logic [1:0] v;
    v = m + 2'd1;
    return mode_e'(v);
  endfunction

endpackage

// File: rtl/switch_led_controller_debounce_filter.sv
// Single-switch debouncer: the stable output follows the raw input only after
// the raw value has differed from it for DEBOUNCE_LIMIT consecutive cycles.
module debounce_filter #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Raw,
  output logic o_Stable
);

  localparam int CNT_W = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [CNT_W-1:0] cnt_p1;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_p1   <= '0;
      o_Stable <= 1'b0;
    end else if (i_Raw != o_Stable) begin
      if (cnt_p1 == CNT_LAST) begin
        o_Stable <= i_Raw;
        cnt_p1   <= '0;
      end else begin
        cnt_p1 <= cnt_p1 + 1'b1;
      end
    end else begin
      // any agreement restarts the window, so short glitches never land
      cnt_p1 <= '0;
    end
  end

endmodule

// File: rtl/switch_led_controller.sv
// Front-panel controller: debounces four switches, advances display mode on
// switch-4 release and drives four registered LEDs from the selected mode.
module switch_led_controller
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int BLINK_PERIOD   = 12500000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  input  logic i_Switch_3,
  input  logic i_Switch_4,
  output logic o_LED_1,
  output logic o_LED_2,
  output logic o_LED_3,
  output logic o_LED_4
);

  localparam int PER_W = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(BLINK_PERIOD - 1);

  logic [3:0] raw_p0;
  logic [3:0] db_p1;
  logic [3:0] db_prev_p2;
  logic [3:0] rel_p2;
  mode_e      mode, mode_next;
  logic       mode_chg;
  logic       running;
  logic       tick;
  logic [PER_W-1:0] per_cnt;
  logic [1:0] phase;
  logic [3:0] count;
  logic [3:0] led_p0;
  logic [3:0] led_p1;
  logic       op_a, op_b, op_c;

  assign raw_p0 = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  // ---- stage 1: debounce
  for (genvar i = 0; i < 4; i++) begin : g_db
    debounce_filter #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_db (
      .i_Clk   (i_Clk),
      .i_Rst   (i_Rst),
      .i_Raw   (raw_p0[i]),
      .o_Stable(db_p1[i])
    );
  end

  // ---- stage 2: release edges
  always_ff @(posedge i_Clk) begin
    if (i_Rst) db_prev_p2 <= '0;
    else       db_prev_p2 <= db_p1;
  end

  assign rel_p2   = db_prev_p2 & ~db_p1;
  assign mode_chg = rel_p2[3];

  always_ff @(posedge i_Clk) begin
    if (i_Rst) mode <= MODE_GATE;
    else       mode <= mode_next;
  end

  always_comb begin
    mode_next = mode;
    if (rel_p2[3]) mode_next = next_mode(mode);
  end

  assign running = (mode == MODE_BLINK) || (mode == MODE_CHASE);
  assign tick    = running && (per_cnt == PER_LAST);

  // phase doubles as BLINK polarity (bit 0) and CHASE position (both bits)
  always_ff @(posedge i_Clk) begin
    if (i_Rst || mode_chg) begin
      per_cnt <= '0;
      phase   <= 2'd0;
    end else if (running) begin
      if (tick) begin
        per_cnt <= '0;
        phase   <= phase + 2'd1;
      end else begin
        per_cnt <= per_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      count <= 4'd0;
    end else if ((mode == MODE_COUNT) && !rel_p2[3]) begin
      if (rel_p2[1])      count <= 4'd0;
      else if (rel_p2[0]) count <= count + 4'd1;
    end
  end

  assign op_a = db_p1[0];
  assign op_b = db_p1[1];
  assign op_c = db_p1[2];

  // ---- stage 3: output mux and LED register
  always_comb begin
    led_p0 = 4'd0;
    unique case (mode)
      MODE_GATE:  led_p0 = {op_a ^ op_b ^ op_c,
                            op_a | op_b | op_c,
                            (op_a & op_b) | (op_a & op_c) | (op_b & op_c),
                            op_a & op_b & op_c};
      MODE_BLINK: led_p0 = phase[0] ? BLINK_PAT_B : BLINK_PAT_A;
      MODE_CHASE: led_p0 = 4'b0001 << phase;
      MODE_COUNT: led_p0 = count;
      default:    led_p0 = 4'd0;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) led_p1 <= 4'd0;
    else       led_p1 <= led_p0;
  end

  assign o_LED_1 = led_p1[0];
  assign o_LED_2 = led_p1[1];
  assign o_LED_3 = led_p1[2];
  assign o_LED_4 = led_p1[3];

endmodule

// File: tb/tb_switch_led_controller.sv
// Scoreboard bench for switch_led_controller with short debounce and blink periods.
module tb_switch_led_controller;

  logic clk;
  logic rst;
  logic sw1, sw2, sw3, sw4;
  logic led1, led2, led3, led4;
  logic [3:0] leds;

  typedef struct {
    string      name;
    logic [3:0] exp;
  } chk_t;

  chk_t sb_q[$];
  logic chk_req;
  int   n_pass;
  int   n_total;

  switch_led_controller #(
    .DEBOUNCE_LIMIT(4),
    .BLINK_PERIOD  (8)
  ) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_Switch_1(sw1),
    .i_Switch_2(sw2),
    .i_Switch_3(sw3),
    .i_Switch_4(sw4),
    .o_LED_1   (led1),
    .o_LED_2   (led2),
    .o_LED_3   (led3),
    .o_LED_4   (led4)
  );

  assign leds = {led4, led3, led2, led1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: pops one expectation per requested sample, away from the active edge
  always @(negedge clk) begin
    if (chk_req) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_underflow: sample requested with empty queue, leds=%b", leds);
      end else begin
        chk_t c;
        c = sb_q.pop_front();
        n_total++;
        if (leds === c.exp) n_pass++;
        else $display("FAIL %s: leds=%b expected=%b", c.name, leds, c.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] exp);
    chk_t c;
    c.name = name;
    c.exp  = exp;
    sb_q.push_back(c);
    chk_req = 1'b1;
    @(negedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic set_sw(input int sw, input logic v);
    case (sw)
      1: sw1 = v;
      2: sw2 = v;
      3: sw3 = v;
      default: sw4 = v;
    endcase
  endtask

  task automatic press_release(input int sw);
    set_sw(sw, 1'b1);
    tick(6);
    set_sw(sw, 1'b0);
    tick(6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, leds=%b", leds);
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    chk_req = 1'b0;
    rst = 1'b1;
    sw1 = 1'b0; sw2 = 1'b0; sw3 = 1'b0; sw4 = 1'b0;
    tick(3);
    rst = 1'b0;
    check("reset_leds", 4'b0000);

    // GATE with all operands high, then with S3 dropped
    sw1 = 1'b1; sw2 = 1'b1; sw3 = 1'b1;
    tick(10);
    check("gate_111", 4'b1111);
    sw3 = 1'b0;
    tick(10);
    check("gate_110", 4'b0110);
    sw1 = 1'b0; sw2 = 1'b0;
    tick(10);
    check("gate_000", 4'b0000);

    // short glitch on S1 must never pass the debouncer
    sw1 = 1'b1;
    tick(2);
    sw1 = 1'b0;
    tick(1);
    check("glitch_mid", 4'b0000);
    tick(10);
    check("glitch_after", 4'b0000);

    // BLINK: 0101 for 8 cycles after entry, then 1010, then 0101
    press_release(4);
    tick(2);
    check("blink_ph0", 4'b0101);
    tick(8);
    check("blink_ph1", 4'b1010);
    tick(8);
    check("blink_ph2", 4'b0101);

    // CHASE: 0001 -> 0010 -> 0100 every 8 cycles
    press_release(4);
    tick(2);
    check("chase_0", 4'b0001);
    tick(8);
    check("chase_1", 4'b0010);
    tick(8);
    check("chase_2", 4'b0100);

    press_release(4);
    tick(2);
    check("count_entry", 4'b0000);

    // 17 increments wrap through 15 -> 0 -> 1
    for (int i = 1; i <= 17; i++) begin
      press_release(1);
      if (i == 15) begin
        tick(2);
        check("count_15", 4'b1111);
      end
      if (i == 16) begin
        tick(2);
        check("count_wrap0", 4'b0000);
      end
    end
    tick(2);
    check("count_17", 4'b0001);
    press_release(2);
    tick(2);
    check("count_clear", 4'b0000);

    for (int i = 0; i < 3; i++) press_release(1);
    tick(2);
    check("count_3", 4'b0011);

    // S2 and S4 released together: mode change wins, count kept
    sw2 = 1'b1; sw4 = 1'b1;
    tick(6);
    sw2 = 1'b0; sw4 = 1'b0;
    tick(8);
    check("dual_rel_gate", 4'b0000);
    sw3 = 1'b1;
    tick(10);
    check("dual_rel_gate_c", 4'b1100);
    sw3 = 1'b0;
    tick(10);
    for (int i = 0; i < 3; i++) press_release(4);
    tick(2);
    check("count_preserved", 4'b0011);

    // into CHASE, then reset during an S4 release debounce
    for (int i = 0; i < 3; i++) press_release(4);
    tick(2);
    check("chase_again", 4'b0001);
    sw4 = 1'b1;
    tick(6);
    sw4 = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_leds", 4'b0000);
    tick(20);
    check("post_rst_quiet", 4'b0000);
    sw1 = 1'b1;
    tick(10);
    check("post_rst_gate", 4'b1100);
    sw1 = 1'b0;
    tick(2);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      $display("FAIL sb_drain: pending=%0d expected=0", sb_q.size());
      n_total += sb_q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
